// File: rtl/regfile_write_bank.sv
// -----------------------------------------------------------------------------
// regfile_write_bank
//
// Write side of a 2**S x N register file. Each cycle the bank accepts at most
// one write through a valid/ready handshake. It decodes the selector into a
// one-hot write enable and exposes every register on one packed bus. A clear
// request starts a sequence that zeroes one register per cycle, from register
// 0 up to register L-1. Writes are refused (wr_ready low) while the clear runs.
//
// Optional build macro: REGFILE_R0_ZERO_EN
//   When defined, register 0 always reads as zero. Writes to selector 0 are
//   still handshaken and still pulse wr_hot[0], but their data is dropped.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   wr_valid   write request valid
//   wr_ready   bank can accept a write this cycle (registered)
//   wr_sel     register index to write (S bits)
//   wr_data    write data (N bits)
//   clr_req    start a clear-all sequence (sampled only when idle)
//   busy       clear sequence in progress
//   wr_hot     one-hot of the register written on the previous edge (pulse)
//   clr_done   one-cycle pulse after the last register has been cleared
//   regs_flat  all registers, register 0 in bits [N-1:0]
// -----------------------------------------------------------------------------
module regfile_write_bank #(
   parameter  int S = 3,
   parameter  int N = 16,
   localparam int L = 2**S
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           wr_valid,
   output logic           wr_ready,
   input  logic [S-1:0]   wr_sel,
   input  logic [N-1:0]   wr_data,
   input  logic           clr_req,
   output logic           busy,
   output logic [L-1:0]   wr_hot,
   output logic           clr_done,
   output logic [N*L-1:0] regs_flat
);

`ifdef REGFILE_R0_ZERO_EN
   localparam bit R0_ZERO = 1'b1;
`else
   localparam bit R0_ZERO = 1'b0;
`endif

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t         state_reg;
   logic [S-1:0]   cnt_reg;
   logic [L-1:0]   wr_hot_reg;
   logic           clr_done_reg;
   logic           busy_reg;
   logic           wr_ready_reg;

   logic           accept;
   logic [L-1:0]   wr_en;
   logic [L-1:0]   clr_en;

   // wr_ready is a register, so the handshake never depends combinationally
   // on the requester's inputs.
   assign accept = wr_valid & wr_ready_reg;

   // Sequencer: IDLE accepts writes. CLEAR walks cnt_reg from 0 to L-1.
   // The counter wraps naturally from L-1 back to 0 on the exit edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         wr_hot_reg   <= '0;
         clr_done_reg <= 1'b0;
         busy_reg     <= 1'b0;
         wr_ready_reg <= 1'b1;
      end else begin
         wr_hot_reg   <= wr_en;
         clr_done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (clr_req) begin
                  state_reg    <= CLEAR;
                  cnt_reg      <= '0;
                  busy_reg     <= 1'b1;
                  wr_ready_reg <= 1'b0;
               end
            end
            CLEAR: begin
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == S'(L - 1)) begin
                  state_reg    <= IDLE;
                  busy_reg     <= 1'b0;
                  wr_ready_reg <= 1'b1;
                  clr_done_reg <= 1'b1;
               end
            end
            default: begin
               state_reg    <= IDLE;
               busy_reg     <= 1'b0;
               wr_ready_reg <= 1'b1;
            end
         endcase
      end
   end

   // Register storage. A write and a clear can never target the same register
   // on the same edge, because writes are refused while CLEAR is active.
   genvar gi;
   generate
      for (gi = 0; gi < L; gi++) begin : g_reg
         logic [N-1:0] q_reg;

         assign wr_en[gi]  = accept && (wr_sel == S'(gi));
         assign clr_en[gi] = (state_reg == CLEAR) && (cnt_reg == S'(gi));

         if (R0_ZERO && gi == 0) begin : g_zero
            assign q_reg = '0;
         end else begin : g_store
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  q_reg <= '0;
               end else if (clr_en[gi]) begin
                  q_reg <= '0;
               end else if (wr_en[gi]) begin
                  q_reg <= wr_data;
               end
            end
         end

         assign regs_flat[gi*N +: N] = q_reg;
      end
   endgenerate

   assign wr_ready = wr_ready_reg;
   assign busy     = busy_reg;
   assign wr_hot   = wr_hot_reg;
   assign clr_done = clr_done_reg;

endmodule

// File: tb/tb_regfile_write_bank.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_bank
//
// Directed bench for regfile_write_bank with S=3, N=16. A behavioural model
// tracks the register contents as an array and the clear as a count of
// registers still to zero. A compare process checks every DUT output against
// the model on each falling clock edge. The directed scenarios also check
// hand-computed literal values that pin down the model.
// -----------------------------------------------------------------------------
module tb_regfile_write_bank;
   localparam int S = 3;
   localparam int N = 16;
   localparam int L = 8;

`ifdef REGFILE_R0_ZERO_EN
   localparam bit R0_ZERO = 1'b1;
`else
   localparam bit R0_ZERO = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           wr_valid;
   logic           wr_ready;
   logic [S-1:0]   wr_sel;
   logic [N-1:0]   wr_data;
   logic           clr_req;
   logic           busy;
   logic [L-1:0]   wr_hot;
   logic           clr_done;
   logic [N*L-1:0] regs_flat;

   regfile_write_bank #(.S(S), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .clr_req   (clr_req),
      .busy      (busy),
      .wr_hot    (wr_hot),
      .clr_done  (clr_done),
      .regs_flat (regs_flat)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [N-1:0] m_regs [L];
   int           m_left;      // registers still to be cleared; 0 means idle
   int           m_idx;       // next register the clear will zero
   logic [L-1:0] m_hot;
   logic         m_done;
   bit           m_acc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < L; i++) m_regs[i] = '0;
         m_left = 0;
         m_idx  = 0;
         m_hot  = '0;
         m_done = 1'b0;
      end else begin
         m_acc  = wr_valid && (m_left == 0);
         m_hot  = m_acc ? (L'(1) << wr_sel) : '0;
         m_done = 1'b0;
         if (m_left > 0) begin
            m_regs[m_idx] = '0;
            m_idx++;
            m_left--;
            m_done = (m_left == 0);
         end else if (clr_req) begin
            m_left = L;
            m_idx  = 0;
         end
         if (m_acc && !(R0_ZERO && wr_sel == 0)) m_regs[wr_sel] = wr_data;
      end
   end

   function automatic logic [N*L-1:0] model_flat();
      logic [N*L-1:0] f;
      for (int i = 0; i < L; i++) f[i*N +: N] = m_regs[i];
      return f;
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("cyc_regs_flat", 128'(regs_flat), 128'(model_flat()));
      chk("cyc_wr_hot",    128'(wr_hot),    128'(m_hot));
      chk("cyc_clr_done",  128'(clr_done),  128'(m_done));
      chk("cyc_busy",      128'(busy),      128'(m_left > 0));
      chk("cyc_wr_ready",  128'(wr_ready),  128'(m_left == 0));
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N-1:0] reg_of(input int i);
      return regs_flat[i*N +: N];
   endfunction

   logic [N*L-1:0] exp_flat;

   initial begin
      rst_n = 1'b0; wr_valid = 1'b0; wr_sel = '0; wr_data = '0; clr_req = 1'b0;
      #12 rst_n = 1'b1;
      #1;
      $display("reset released");
      chk("rst_regs_flat", 128'(regs_flat), 128'd0);
      chk("rst_wr_ready",  128'(wr_ready),  128'd1);
      chk("rst_busy",      128'(busy),      128'd0);
      chk("rst_wr_hot",    128'(wr_hot),    128'd0);
      tick();

      // 1: single write
      wr_valid = 1'b1; wr_sel = 3'd5; wr_data = 16'hBEEF;
      tick();
      wr_valid = 1'b0;
      $display("write sel=5 data=beef");
      chk("s1_reg5",   128'(reg_of(5)), 128'h0000_BEEF);
      chk("s1_hot",    128'(wr_hot),    128'h20);
      chk("s1_others", 128'(regs_flat & ~(128'hFFFF << 80)), 128'd0);
      tick();
      chk("s1_hot_off", 128'(wr_hot), 128'd0);

      // 2: back-to-back writes
      for (int i = 0; i < L; i++) begin
         chk("s2_ready", 128'(wr_ready), 128'd1);
         wr_valid = 1'b1; wr_sel = S'(i); wr_data = 16'h1000 + 16'(i);
         tick();
         $display("write sel=%0d data=%h", i, wr_data);
      end
      wr_valid = 1'b0;
      for (int i = 0; i < L; i++) exp_flat[i*N +: N] = 16'h1000 + 16'(i);
      if (R0_ZERO) exp_flat[N-1:0] = '0;
      chk("s2_flat", 128'(regs_flat), 128'(exp_flat));

      // 3: clear-all
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      $display("clear requested");
      chk("s3_busy0",  128'(busy),     128'd1);
      chk("s3_ready0", 128'(wr_ready), 128'd0);
      for (int k = 1; k <= L; k++) begin
         tick();
         chk("s3_reg_cleared", 128'(reg_of(k-1)), 128'd0);
         chk("s3_busy",        128'(busy),        128'(k < L));
         chk("s3_done",        128'(clr_done),    128'(k == L));
      end
      chk("s3_ready_back", 128'(wr_ready), 128'd1);
      tick();
      chk("s3_done_off", 128'(clr_done), 128'd0);

      // 4: write held through a clear
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      wr_valid = 1'b1; wr_sel = 3'd2; wr_data = 16'h55AA;
      for (int k = 1; k <= L; k++) begin
         tick();
         chk("s4_no_change", 128'(regs_flat), 128'd0);
      end
      tick();
      wr_valid = 1'b0;
      $display("held write sel=2 accepted after clear");
      chk("s4_reg2", 128'(reg_of(2)), 128'h55AA);
      chk("s4_hot",  128'(wr_hot),    128'h04);

      // 5: write and clear on the same edge
      clr_req = 1'b1; wr_valid = 1'b1; wr_sel = 3'd7; wr_data = 16'h0F0F;
      tick();
      clr_req = 1'b0; wr_valid = 1'b0;
      $display("write sel=7 with clear");
      chk("s5_reg7_c0", 128'(reg_of(7)), 128'h0F0F);
      for (int k = 1; k <= L; k++) begin
         tick();
         chk("s5_reg7", 128'(reg_of(7)), (k < L) ? 128'h0F0F : 128'd0);
         chk("s5_done", 128'(clr_done),  128'(k == L));
      end
      tick();

      // 6: async reset in the middle of a clear
      for (int i = 1; i < L; i++) begin
         wr_valid = 1'b1; wr_sel = S'(i); wr_data = 16'hA000 + 16'(i);
         tick();
      end
      wr_valid = 1'b0;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick(); tick(); tick();
      chk("s6_nonzero", 128'(reg_of(5)), 128'hA005);
      #2 rst_n = 1'b0;
      #1;
      $display("async reset mid-clear");
      chk("s6_flat",  128'(regs_flat), 128'd0);
      chk("s6_busy",  128'(busy),      128'd0);
      chk("s6_done",  128'(clr_done),  128'd0);
      @(posedge clk); @(posedge clk);
      #3 rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("s6_no_done", 128'(clr_done), 128'd0);
      end

`ifdef REGFILE_R0_ZERO_EN
      wr_valid = 1'b1; wr_sel = 3'd0; wr_data = 16'hFFFF;
      tick();
      wr_valid = 1'b0;
      $display("write sel=0 data=ffff (r0 hardwired)");
      chk("r0_zero", 128'(reg_of(0)), 128'd0);
      chk("r0_hot",  128'(wr_hot),    128'h01);
`else
      wr_valid = 1'b1; wr_sel = 3'd0; wr_data = 16'hFFFF;
      tick();
      wr_valid = 1'b0;
      $display("write sel=0 data=ffff");
      chk("r0_written", 128'(reg_of(0)), 128'hFFFF);
      chk("r0_hot",     128'(wr_hot),    128'h01);
`endif
      tick(); tick();

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule
